// File: rtl/axi_cdc_fifo_rd.sv
// Reader half of a gray-pointer asynchronous FIFO: synchronizes the writer's
// pointer, pops entries into a single output register, and returns a gray read pointer.
module axi_cdc_fifo_rd #(
  parameter int DataWidth  = 8,
  parameter int LogDepth   = 1,
  parameter int SyncStages = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [(2**LogDepth)*DataWidth-1:0]  async_data_i,
  input  logic [LogDepth:0]                   async_wptr_i,
  output logic [LogDepth:0]                   async_rptr_o,
  output logic [DataWidth-1:0]                dst_data_o,
  output logic                                dst_valid_o,
  input  logic                                dst_ready_i
);
  localparam int PtrW = LogDepth + 1;

  if (LogDepth < 1 || SyncStages < 1 || DataWidth < 1) begin : g_bad_params
    $error("axi_cdc_fifo_rd: LogDepth, SyncStages and DataWidth must all be >= 1");
  end

  function automatic logic [PtrW-1:0] gray(input logic [PtrW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [PtrW-1:0]      wsync_q [SyncStages];
  logic [PtrW-1:0]      wsync_d [SyncStages];
  logic [PtrW-1:0]      wptr_sync;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [PtrW-1:0]      rgray_q, rgray_d;
  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [DataWidth-1:0] entry;
  logic                 empty, load;

  always_comb begin
    wsync_d[0] = async_wptr_i;
    for (int i = 1; i < SyncStages; i++) begin
      wsync_d[i] = wsync_q[i-1];
    end
  end

  assign wptr_sync = wsync_q[SyncStages-1];

  // Empty compared in gray space: the synchronized pointer is never decoded to binary.
  always_comb begin
    empty   = (gray(rptr_q) == wptr_sync);
    load    = !empty && (!valid_q || dst_ready_i);
    entry   = async_data_i[DataWidth*int'(rptr_q[LogDepth-1:0]) +: DataWidth];
    rptr_d  = rptr_q + PtrW'(load);
    valid_d = load || (valid_q && !dst_ready_i);
    data_d  = load ? entry : data_q;
    // Registered from the current pointer, so the writer sees a pop one edge after it happens.
    rgray_d = gray(rptr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) begin
        wsync_q[i] <= '0;
      end
      rptr_q  <= '0;
      rgray_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < SyncStages; i++) begin
        wsync_q[i] <= wsync_d[i];
      end
      rptr_q  <= rptr_d;
      rgray_q <= rgray_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign async_rptr_o = rgray_q;
  assign dst_valid_o  = valid_q;
  assign dst_data_o   = data_q;

endmodule

// File: tb/tb_axi_cdc_fifo_rd.sv
// Bench for axi_cdc_fifo_rd: the bench acts as the writer domain, queues each
// written word as the expected response, and a monitor checks every handshake.
module tb_axi_cdc_fifo_rd;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] async_data;
  logic [1:0]  async_wptr;
  logic [1:0]  async_rptr;
  logic [7:0]  dst_data;
  logic        dst_valid;
  logic        dst_ready;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [1:0] rlog[$];
  logic [1:0] last_r;
  logic       log_en = 1'b0;
  logic [1:0] wbin;

  axi_cdc_fifo_rd #(.DataWidth(8), .LogDepth(1), .SyncStages(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .async_data_i(async_data),
    .async_wptr_i(async_wptr),
    .async_rptr_o(async_rptr),
    .dst_data_o  (dst_data),
    .dst_valid_o (dst_valid),
    .dst_ready_i (dst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writer side: store the word, then advance the gray write pointer.
  task automatic push_word(input logic [7:0] d);
    async_data[int'(wbin[0])*8 +: 8] = d;
    wbin       = wbin + 2'd1;
    async_wptr = wbin ^ (wbin >> 1);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    dst_ready  = 1'b0;
    wbin       = 2'd0;
    async_wptr = 2'b00;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [1:0] g2b(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Scoreboard monitor: every handshake must match the oldest written word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dst_valid && dst_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got word %0h expected no word", dst_data);
        end else begin
          chk("sb_data", dst_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (log_en && async_rptr != last_r) begin
        rlog.push_back(async_rptr);
        last_r = async_rptr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_log [7];
    int         sent;
    int         guard;
    exp_log = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

    rst        = 1'b1;
    dst_ready  = 1'b0;
    async_data = 16'h0000;
    async_wptr = 2'b01;
    wbin       = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_valid", dst_valid, 0);
    chk("reset_data", dst_data, 0);
    chk("reset_rptr", async_rptr, 0);
    async_wptr = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word: pointer change just after edge 0, visible after edge 3.
    @(posedge clk); #1;
    dst_ready = 1'b1;
    push_word(8'hA5);
    @(posedge clk); #1;
    chk("single_e1_valid", dst_valid, 0);
    @(posedge clk); #1;
    chk("single_e2_valid", dst_valid, 0);
    @(posedge clk); #1;
    chk("single_e3_valid", dst_valid, 1);
    chk("single_e3_data", dst_data, 8'hA5);
    chk("single_e3_rptr", async_rptr, 2'b00);
    @(posedge clk); #1;
    chk("single_e4_valid", dst_valid, 0);
    chk("single_e4_rptr", async_rptr, 2'b01);

    // Backpressure: two words queued, consumer stalled.
    do_reset();
    push_word(8'hA5);
    @(posedge clk); #1;
    push_word(8'h5A);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", dst_valid, 1);
      chk("bp_hold_data", dst_data, 8'hA5);
      chk("bp_hold_rptr", async_rptr, 2'b01);
      @(posedge clk); #1;
    end
    dst_ready = 1'b1;
    @(posedge clk); #1;
    dst_ready = 1'b0;
    chk("bp_pulse_valid", dst_valid, 1);
    chk("bp_pulse_data", dst_data, 8'h5A);
    @(posedge clk); #1;
    chk("bp_pulse_rptr", async_rptr, 2'b11);

    // Reset between edges while holding 0x5A.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid", dst_valid, 0);
    chk("midrst_data", dst_data, 0);
    chk("midrst_rptr", async_rptr, 0);
    async_wptr = 2'b00;
    wbin       = 2'd0;
    exp_q.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    dst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_after_valid", dst_valid, 0);
    end

    // Full FIFO drained back to back.
    do_reset();
    dst_ready = 1'b1;
    push_word(8'h11);
    @(posedge clk); #1;
    push_word(8'h22);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full_e3_valid", dst_valid, 1);
    chk("full_e3_data", dst_data, 8'h11);
    @(posedge clk); #1;
    chk("full_e4_valid", dst_valid, 1);
    chk("full_e4_data", dst_data, 8'h22);
    @(posedge clk); #1;
    chk("full_e5_valid", dst_valid, 0);
    chk("full_e5_rptr", async_rptr, 2'b11);

    // Wrap-around: six words with flow control from the returned read pointer.
    do_reset();
    rlog.delete();
    rlog.push_back(2'b00);
    last_r = 2'b00;
    log_en = 1'b1;
    sent   = 0;
    guard  = 0;
    while (sent < 6 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
      dst_ready = ~dst_ready;
      if (wbin - g2b(async_rptr) != 2'd2) begin
        push_word(8'(sent + 1));
        sent++;
      end
    end
    chk("wrap_sent", sent, 6);
    dst_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    log_en = 1'b0;
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_rlog_len", rlog.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < rlog.size()) chk("wrap_rptr_seq", rlog[i], exp_log[i]);
    end
    chk("wrap_final_valid", dst_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_cdc_fifo_rd.md
AXI_CDC_FIFO_RD -- requirements
Module: axi_cdc_fifo_rd

Interface
REQ-001 The block SHALL be the single-clock reader end of a gray-pointer asynchronous FIFO, i.e. the destination half of one AXI channel of a clock domain crossing.
REQ-002 Parameter DataWidth, default 8, payload width in bits.
REQ-003 Parameter LogDepth, default 1, FIFO depth is 2**LogDepth entries.
REQ-004 Parameter SyncStages, default 2, number of synchronizer flops on the incoming write pointer.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-006 clk_i  in  1  reader-domain clock.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 async_data_i  in  (2**LogDepth)*DataWidth  writer-owned storage array; entry k occupies bits [k*DataWidth +: DataWidth].
REQ-009 async_wptr_i  in  LogDepth+1  gray-coded write pointer from the writer domain.
REQ-010 async_rptr_o  out  LogDepth+1  gray-coded read pointer to the writer domain.
REQ-011 dst_data_o  out  DataWidth  popped payload.
REQ-012 dst_valid_o  out  1  payload valid.
REQ-013 dst_ready_i  in  1  consumer ready.

Function
REQ-014 async_wptr_i SHALL pass through a SyncStages-deep flop chain before any use; the last stage is wptr_sync.
REQ-015 The read pointer rptr_q SHALL be a binary counter of LogDepth+1 bits that wraps modulo 2**(LogDepth+1).
REQ-016 async_rptr_o SHALL be driven directly from a flop holding gray(rptr_q), with no combinational logic after it; gray(x) = x XOR (x>>1).
REQ-017 The FIFO SHALL be empty exactly when gray(rptr_q) equals wptr_sync; no binary decode of wptr_sync is allowed.
REQ-018 The output stage SHALL be a single register (valid_q, data_q) driving dst_valid_o and dst_data_o.
REQ-019 load = !empty AND (!valid_q OR dst_ready_i); on load, data_q <= entry rptr_q[LogDepth-1:0], valid_q <= 1, and rptr_q increments.
REQ-020 When dst_valid_o=1 AND dst_ready_i=1 AND the FIFO is empty, valid_q SHALL clear on the next edge.
REQ-021 While dst_valid_o=1 AND dst_ready_i=0, dst_data_o and dst_valid_o SHALL hold stable and rptr_q SHALL NOT advance.
REQ-022 A simultaneous handshake and non-empty FIFO SHALL reload in the same edge, sustaining 1 word/cycle.
REQ-023 Latency from an async_wptr_i change (sampled at edge 0) to dst_valid_o=1 SHALL be SyncStages+1 edges when the output register is free.
REQ-024 async_rptr_o SHALL update one edge after each load.
REQ-025 The block SHALL never pop when empty and SHALL never read an entry before its write pointer has been synchronized.
REQ-026 Elaboration SHALL fail if LogDepth < 1, SyncStages < 1, or DataWidth < 1.

Reset
REQ-027 While rst_i=1, all synchronizer stages, rptr_q, async_rptr_o, valid_q and data_q SHALL be 0, taking effect immediately and independent of clk_i.
REQ-028 Reset asserted mid-transfer SHALL drop dst_valid_o immediately and discard the held word; after release the block SHALL treat wptr_sync=0 as empty.

Verification
REQ-029 Reset: rst_i=1 with async_wptr_i=2'b01 -> dst_valid_o=0, dst_data_o=0, async_rptr_o=2'b00.
REQ-030 Single word (DataWidth=8, LogDepth=1, SyncStages=2): entry0=0xA5, async_wptr_i 00->01 at edge 0, dst_ready_i=1 -> dst_valid_o=1 with dst_data_o=0xA5 after edge 3; async_rptr_o=01 after edge 4; dst_valid_o=0 after edge 4.
REQ-031 Backpressure: entries 0xA5 and 0x5A, async_wptr_i=11, dst_ready_i=0 -> dst_data_o holds 0xA5 for 10 cycles and async_rptr_o stays 01; a 1-cycle ready pulse -> dst_data_o=0x5A next edge and async_rptr_o=11.
REQ-032 Full FIFO: async_wptr_i=11 with rptr 00 and dst_ready_i=1 -> two back-to-back words are delivered, then dst_valid_o=0 and async_rptr_o=11.
REQ-033 Wrap-around: stream 6 words 0x01..0x06 through depth 2 -> async_rptr_o follows 00,01,11,10,00,01,11, all data arrives in order, and no word is duplicated or lost.
REQ-034 Reset mid-operation: dst_valid_o=1 holding 0x5A, rst_i pulsed between edges -> dst_valid_o=0 before the next edge; after release with async_wptr_i=00, no output.
